// File: rtl/imem_loadable.sv
// Word-organised instruction memory with a byte-enabled loader port, a registered
// fetch port with fault reporting, and a one-word-per-cycle clear sweep.
module imem_loadable #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 4096,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter logic [31:0] FAULT_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              init_busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  output logic              ld_ready,
  output logic              ld_err
);

  localparam int WORDS  = DEPTH_BYTES / 4;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DEPTH_BYTES);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             run;

  // Words are stored in address order: bits [8k+7:8k] hold the byte at offset k.
  logic [31:0] mem [WORDS];

  logic             fetch_ok;
  logic [IDX_W-1:0] fetch_widx;
  logic             ld_in_range;
  logic [IDX_W-1:0] ld_widx;
  logic [31:0]      ld_data_mem;
  logic [3:0]       ld_be_mem;

  // Converts between address-ordered storage and instruction-word order; the
  // big-endian swap is its own inverse, so it serves both directions.
  function automatic logic [31:0] reorder(input logic [31:0] w);
    return BIG_ENDIAN ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  assign run         = (state_q == RUN);
  assign init_busy   = (state_q == CLEAR);
  assign fetch_ready = run;
  assign ld_ready    = run;

  assign fetch_ok    = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> BYTE_W) == '0);
  assign fetch_widx  = fetch_addr[BYTE_W-1:2];
  assign ld_in_range = (ld_addr >> BYTE_W) == '0;
  assign ld_widx     = ld_addr[BYTE_W-1:2];
  assign ld_data_mem = reorder(ld_data);
  assign ld_be_mem   = BIG_ENDIAN ? {ld_be[0], ld_be[1], ld_be[2], ld_be[3]} : ld_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(WORDS - 1)) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end
      end
      RUN: begin
        if (flush) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // NOTE: the array has no reset branch on purpose; the CLEAR sweep zeroes it one
  // word per cycle, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (ld_valid && ld_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (ld_be_mem[k]) mem[ld_widx][8*k +: 8] <= ld_data_mem[8*k +: 8];
      end
    end
  end

  // Reading mem here sees the pre-edge word, giving read-before-write on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_instr <= '0;
      ld_err      <= 1'b0;
    end else begin
      fetch_valid <= run && fetch_req;
      fetch_fault <= run && fetch_req && !fetch_ok;
      ld_err      <= run && ld_valid && !ld_in_range;
      if (run && fetch_req) begin
        fetch_instr <= fetch_ok ? reorder(mem[fetch_widx]) : FAULT_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed plan steps plus randomized traffic
// scored against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_imem_loadable;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        init_busy;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  ld_be = '0;
  logic        ld_ready;
  logic        ld_err;

  imem_loadable #(
    .ADDR_W(32), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .FAULT_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .init_busy(init_busy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .ld_ready(ld_ready), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference: a plain byte array; the byte at address A is instr[31:24] of its word.
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] last_instr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a & 32'h0000_0FFC);
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = ref_mem[base+k];
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int base;
    base = int'(a & 32'h0000_0FFC);
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[base + 3 - i] = d[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; ld_valid = 1'b0; flush = 1'b0; ld_be = 4'h0;
  endtask

  // One RUN cycle: drive, predict from the reference, clock, then compare.
  task automatic do_cycle(input string name, input logic fr, input logic [31:0] fa,
                          input logic lv, input logic [31:0] la, input logic [31:0] ld,
                          input logic [3:0] lbe, input logic fl);
    logic exp_f, exp_e;
    check({name, ".ready"}, fetch_ready, 1'b1);
    fetch_req = fr; fetch_addr = fa; ld_valid = lv; ld_addr = la;
    ld_data = ld; ld_be = lbe; flush = fl;
    exp_f = fr && ((fa[1:0] != 2'b00) || (fa >= DEPTH));
    if (fr) last_instr = exp_f ? NOP : model_read(fa);
    exp_e = lv && (la >= DEPTH);
    if (lv && !exp_e) model_write(la, ld, lbe);
    if (fl) model_clear();
    @(posedge clk); #1;
    idle_inputs();
    check({name, ".valid"}, fetch_valid, fr);
    check({name, ".fault"}, fetch_fault, exp_f);
    check({name, ".instr"}, fetch_instr, last_instr);
    check({name, ".ld_err"}, ld_err, exp_e);
  endtask

  // Counts busy cycles from the current sample point; bounded so it cannot hang.
  task automatic wait_clear(input string name);
    int n;
    logic bad;
    n = 0; bad = 1'b0;
    while (init_busy && n < 2000) begin
      if (fetch_valid || ld_err || fetch_ready || ld_ready) bad = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    check({name, ".busy_cycles"}, n, 1024);
    check({name, ".quiet_during_clear"}, bad, 1'b0);
    check({name, ".no_resp_at_entry"}, fetch_valid, 1'b0);
    idle_inputs();
    model_clear();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return 32'h1000 + 32'($urandom_range(0, 3)) * 4;
    if (r == 2) return 32'h40 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    return 32'h40 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fa, la;
    model_clear();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.init_busy", init_busy, 1'b1);
    check("rst.fetch_ready", fetch_ready, 1'b0);
    check("rst.ld_ready", ld_ready, 1'b0);
    check("rst.fetch_valid", fetch_valid, 1'b0);
    check("rst.fetch_instr", fetch_instr, 32'h0);
    check("rst.fetch_fault", fetch_fault, 1'b0);
    check("rst.ld_err", ld_err, 1'b0);

    // Clear after reset, with requests held that must be ignored
    fetch_req = 1'b1; fetch_addr = 32'h0;
    ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'hFFFF_FFFF; ld_be = 4'hF;
    rst = 1'b0;
    wait_clear("por");
    do_cycle("first_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("first_fetch.zero", fetch_instr, 32'h0);
    do_cycle("clr_ld_ignored", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Load and readback, full word then a single low lane
    do_cycle("ld_full", 1'b0, 32'h0, 1'b1, 32'h10, 32'h00500093, 4'hF, 1'b0);
    do_cycle("rb_full", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("rb_full.const", fetch_instr, 32'h00500093);
    do_cycle("ld_lane0", 1'b0, 32'h0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
    do_cycle("rb_lane0", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("rb_lane0.const", fetch_instr, 32'h005000AA);

    // Faults
    do_cycle("f_misalign", 1'b1, 32'h12, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("f_misalign.const", fetch_instr, NOP);
    do_cycle("f_range", 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    do_cycle("f_upper", 1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    do_cycle("ld_oor", 1'b0, 32'h0, 1'b1, 32'h2000, 32'h12345678, 4'hF, 1'b0);
    do_cycle("ld_oor_pulse_end", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("ld_oor.unchanged", fetch_instr, 32'h005000AA);
    do_cycle("no_fetch_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Same-cycle load and fetch to one word
    do_cycle("col_pre", 1'b0, 32'h0, 1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0);
    do_cycle("col", 1'b1, 32'h20, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0);
    check("col.old", fetch_instr, 32'h11111111);
    do_cycle("col_after", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("col_after.new", fetch_instr, 32'hDEADBEEF);

    // Streaming fetches on consecutive cycles
    for (int i = 0; i < 4; i++)
      do_cycle("st_ld", 1'b0, 32'h0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle("stream", 1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      check("stream.const", fetch_instr, 32'hC0DE_0000 + 32'(i));
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      fa = rand_addr();
      la = rand_addr();
      do_cycle("rnd", 1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), la,
               $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end

    // Flush with a same-cycle fetch, then reset partway into the clear
    do_cycle("ld_keep", 1'b0, 32'h0, 1'b1, 32'h30, 32'hA5A5_5A5A, 4'hF, 1'b0);
    do_cycle("flush", 1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("flush.const", fetch_instr, 32'hA5A5_5A5A);
    check("flush.busy", init_busy, 1'b1);
    repeat (99) @(posedge clk);
    #1;
    check("flush.busy_99", init_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.busy", init_busy, 1'b1);
    flush = 1'b1;
    rst = 1'b0;
    last_instr = '0;
    wait_clear("midrst");
    do_cycle("post_clr_30", 1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("post_clr_30.zero", fetch_instr, 32'h0);
    do_cycle("post_clr_10", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check("post_clr_10.zero", fetch_instr, 32'h0);
    do_cycle("post_clr_20", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed 4 KB byte-array instruction memory.
- Adds a word-write loader port for program download, a registered fetch port with a valid handshake, fault reporting, selectable byte order, and a sequenced clear.
- Storage is word-organised (WORDS = DEPTH_BYTES/4).
- The clear sweeps one word per cycle instead of zeroing the whole array in the reset branch.
- Sits between the fetch stage (fetch port) and the boot/debug loader (load port).

Parameters:
- ADDR_W, 32, width of fetch and load byte addresses.
- DEPTH_BYTES, 4096, memory size in bytes; power of two, at least 8.
- BIG_ENDIAN, 1, 1: byte at address A is instr[31:24]; 0: byte at A is instr[7:0].
- FAULT_INSTR, 32'h00000013, word returned on a faulted fetch (NOP).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  single-cycle pulse; re-enters CLEAR from RUN.
- init_busy  out  1  high while in CLEAR.
- fetch_req  in  1  fetch request, sampled when fetch_ready=1.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_ready  out  1  high in RUN.
- fetch_valid  out  1  response valid, one cycle after an accepted request.
- fetch_instr  out  32  fetched instruction word.
- fetch_fault  out  1  qualifies fetch_valid: misaligned or out-of-range address.
- ld_valid  in  1  load write request.
- ld_addr  in  ADDR_W  load byte address; bits [1:0] ignored.
- ld_data  in  32  load word, in instruction-word byte order.
- ld_be  in  4  byte enables; ld_be[i] covers ld_data[8i+7:8i].
- ld_ready  out  1  high in RUN.
- ld_err  out  1  one-cycle pulse when an out-of-range load is dropped.

Behaviour:
- States: CLEAR, RUN. A 2-bit counter is not required; a clear index ceil(log2(WORDS)) bits wide is.
- Reset (async, rst=1):
  - state=CLEAR, clear index=0.
  - fetch_valid=0, fetch_instr=0, fetch_fault=0, ld_err=0.
  - init_busy=1, fetch_ready=0, ld_ready=0.
- CLEAR:
  - Each cycle writes 0 to word[index], then index++.
  - After the write to word WORDS-1, the next state is RUN. CLEAR takes exactly WORDS cycles after rst falls.
  - fetch_req and ld_valid are ignored: no response, no write, no ld_err.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from index 0.
- flush=1 in RUN:
  - Next state is CLEAR, index=0.
  - A fetch or load presented in the same cycle is still serviced.
  - flush in CLEAR is ignored; the sweep does not restart.
- Fetch (RUN, fetch_req=1), response on the next edge:
  - fetch_valid=1.
  - fetch_fault=1 if fetch_addr[1:0]!=0 or fetch_addr>=DEPTH_BYTES; fetch_instr is then FAULT_INSTR.
  - Otherwise fetch_fault=0 and fetch_instr = word[fetch_addr/4], bytes ordered per BIG_ENDIAN.
- When no fetch was accepted in the previous cycle:
  - fetch_valid=0 and fetch_fault=0.
  - fetch_instr holds its last value.
- Back-to-back fetches are accepted every cycle (full throughput, latency 1).
- Load (RUN, ld_valid=1):
  - In range (ld_addr < DEPTH_BYTES): each enabled byte lane is written at the edge; disabled lanes are unchanged.
  - Out of range: no write, and ld_err=1 for exactly the following cycle.
  - Lane-to-address mapping follows BIG_ENDIAN. A word written as ld_data with ld_be=4'hF reads back as the same value on fetch_instr.
- Same-cycle fetch and load to the same word: the fetch returns pre-write data (read-before-write). The new data is visible to a fetch issued one cycle later.
- Address arithmetic is unsigned with no wrap; upper address bits take part in the range check.

Test Plan:
- Reset→clear: pulse rst, release, hold fetch_req=1 to 0x0. Required: init_busy=1 for exactly 1024 cycles (DEPTH_BYTES=4096), no fetch_valid during CLEAR. The first RUN fetch returns 0x00000000, fault=0.
- Load/readback, BIG_ENDIAN=1: load 0x00500093 at 0x10 with be=F, then fetch 0x10. Required: fetch_instr=0x00500093 one cycle later. Then load 0x000000AA at 0x10 with be=4'b0001 and fetch 0x10. Required: 0x005000AA.
- Faults: fetch 0x12. Required: fault=1, instr=0x00000013. Fetch 0x1000. Required: fault=1. Load to 0x2000. Required: ld_err pulses 1 cycle, memory unchanged.
- Collision: in one cycle, load 0xDEADBEEF to 0x20 and fetch 0x20 (old word 0x11111111). Required: first response 0x11111111; next fetch returns 0xDEADBEEF.
- Streaming: fetch 0x0,0x4,0x8,0xC on consecutive cycles. Required: four consecutive fetch_valid cycles returning the words in order.
- Flush and mid-clear reset: flush in RUN. Required: init_busy rises next cycle. Assert rst 100 cycles into the clear. Required: the clear restarts and is busy for the full 1024 cycles. Previously loaded words read back as 0.
